// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture controller.
//   STATE_W     : width of the exported state code
//   la_state_e  : controller states; the encoding is visible on state_o
package la_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_READ  = 3'd4
  } la_state_e;
endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry readout buffer between the memory read port and the readout sink.
//   clk, rst_n : clock, async active-low reset
//   flush      : drop all entries (abort)
//   push/push_data : word returning from memory
//   pop        : sink took the head word
//   count      : entries held (0..2)
//   head_data  : oldest entry; stays put until popped
module rd_skid_buf #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  logic [DATA_LEN-1:0] push_data,
  input  logic                pop,
  output logic [1:0]          count,
  output logic [DATA_LEN-1:0] head_data
);
  logic [1:0][DATA_LEN-1:0] slot;
  logic                     wr_idx, rd_idx;

  assign head_data = slot[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot   <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_idx] <= push_data;
        wr_idx       <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/capture_ctrl.sv
// Trigger-based capture controller: fills a circular buffer with PRE_TRIG
// samples, waits for a masked trigger match, captures the remaining
// DEPTH-PRE_TRIG samples, then streams all DEPTH words out oldest-first
// over a valid/ready port.
//   arm_i/abort_i             : start / cancel
//   sample_i/sample_valid_i   : probe input
//   trig_mask_i/trig_value_i  : trigger compare
//   mem_* (write)             : capture writes into external dual-port RAM
//   mem_* (read), mem_data_i  : readout reads, 1-cycle latency
//   rd_data/valid/ready/last  : readout stream
//   busy_o, done_o, state_o   : status
module capture_ctrl
  import la_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_LEN = $clog2(DEPTH),
  parameter int PRE_TRIG = DEPTH/2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm_i,
  input  logic                abort_i,
  input  logic [DATA_LEN-1:0] sample_i,
  input  logic                sample_valid_i,
  input  logic [DATA_LEN-1:0] trig_mask_i,
  input  logic [DATA_LEN-1:0] trig_value_i,
  output logic                mem_wen_o,
  output logic [ADDR_LEN-1:0] mem_wr_addr_o,
  output logic [DATA_LEN-1:0] mem_data_o,
  output logic                mem_ren_o,
  output logic [ADDR_LEN-1:0] mem_rd_addr_o,
  input  logic [DATA_LEN-1:0] mem_data_i,
  output logic [DATA_LEN-1:0] rd_data_o,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic                rd_last_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [STATE_W-1:0]  state_o
);
  localparam int CW = ADDR_LEN + 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] WORD_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  la_state_e           state, state_nxt;
  // One pointer serves both phases: after the last capture write it already
  // points at the oldest sample, which is where the readout starts.
  logic [ADDR_LEN-1:0] ptr;
  logic [CW-1:0]       cnt;      // FILL/POST: samples written; READ: reads issued
  logic [CW-1:0]       rd_cnt;   // words handed to the sink
  logic                inflight; // read issued last cycle, data on mem_data_i now
  logic [1:0]          occ;
  logic                capturing, wr, trig, pop, ren, last_pop;

  assign capturing = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);
  assign wr        = capturing & sample_valid_i & ~abort_i;
  assign trig      = ((sample_i ^ trig_value_i) & trig_mask_i) == '0;
  assign pop       = rd_valid_o & rd_ready_i & ~abort_i;
  assign last_pop  = pop & rd_last_o;
  // Reserve a buffer slot for every in-flight word so nothing is ever dropped.
  assign ren = (state == ST_READ) && !abort_i && (cnt != WORD_CNT) &&
               (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  assign mem_wen_o     = wr;
  assign mem_wr_addr_o = ptr;
  assign mem_data_o    = sample_i;
  assign mem_ren_o     = ren;
  assign mem_rd_addr_o = ptr;
  assign rd_valid_o    = (occ != 2'd0);
  assign rd_last_o     = rd_valid_o && (rd_cnt == WORD_LAST);
  assign busy_o        = (state != ST_IDLE);
  assign state_o       = state;

  rd_skid_buf #(.DATA_LEN(DATA_LEN)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_i),
    .push      (inflight),
    .push_data (mem_data_i),
    .pop       (pop),
    .count     (occ),
    .head_data (rd_data_o)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (arm_i) state_nxt = (PRE_TRIG > 0) ? ST_FILL : ST_ARMED;
      ST_FILL:  if (wr && cnt == PRE_LAST) state_nxt = ST_ARMED;
      ST_ARMED: if (wr && trig) state_nxt = (POST_LAST == '0) ? ST_READ : ST_POST;
      ST_POST:  if (wr && cnt == POST_LAST) state_nxt = ST_READ;
      ST_READ:  if (last_pop) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_i) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      rd_cnt   <= '0;
      inflight <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= ren;
      done_o   <= last_pop;
      if (state == ST_IDLE) begin
        if (arm_i && !abort_i) begin
          ptr    <= '0;
          cnt    <= '0;
          rd_cnt <= '0;
        end
      end else begin
        if (wr || ren) ptr <= ptr + ADDR_LEN'(1);
        unique case (state)
          ST_FILL:  if (wr) cnt <= (cnt == PRE_LAST) ? '0 : cnt + CNT_ONE;
          // Trigger sample counts as post-sample 1.
          ST_ARMED: if (wr && trig) cnt <= (POST_LAST == '0) ? '0 : CNT_ONE;
          ST_POST:  if (wr) cnt <= (cnt == POST_LAST) ? '0 : cnt + CNT_ONE;
          ST_READ: begin
            if (ren) cnt    <= cnt + CNT_ONE;
            if (pop) rd_cnt <= rd_cnt + CNT_ONE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, sample and memory word width.
REQ-002 SHALL have parameter DEPTH, default 1024, capture buffer words; power of two, at least 4.
REQ-003 SHALL have parameter ADDR_LEN, default $clog2(DEPTH), memory address width.
REQ-004 SHALL have parameter PRE_TRIG, default DEPTH/2, samples kept before the trigger; legal range 0..DEPTH-1.
REQ-005 SHALL have ports in this order:
- clk  in  1  single clock; both memory ports run on it.
- rst_n  in  1  asynchronous reset, active low.
- arm_i  in  1  start-capture pulse.
- abort_i  in  1  cancel any operation.
- sample_i  in  DATA_LEN  probe sample.
- sample_valid_i  in  1  sample_i is valid this cycle.
- trig_mask_i  in  DATA_LEN  trigger compare mask.
- trig_value_i  in  DATA_LEN  trigger compare value.
- mem_wen_o  out  1  memory write enable.
- mem_wr_addr_o  out  ADDR_LEN  memory write address.
- mem_data_o  out  DATA_LEN  memory write data.
- mem_ren_o  out  1  memory read enable.
- mem_rd_addr_o  out  ADDR_LEN  memory read address.
- mem_data_i  in  DATA_LEN  memory read data, valid one cycle after mem_ren_o.
- rd_data_o  out  DATA_LEN  readout word.
- rd_valid_o  out  1  readout word is valid.
- rd_ready_i  in  1  readout sink accepts the word.
- rd_last_o  out  1  final word of the readout.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse when the readout completes.
- state_o  out  3  current state encoding.

Function
REQ-006 SHALL implement states IDLE=0, FILL=1, ARMED=2, POST=3, READ=4.
REQ-007 SHALL leave IDLE on arm_i: go to FILL when PRE_TRIG>0, otherwise to ARMED; clear wr_ptr and counters. arm_i SHALL be ignored in all other states.
REQ-008 SHALL drive the write port as follows in FILL, ARMED and POST:
- mem_wen_o = sample_valid_i, combinationally.
- mem_data_o = sample_i.
- mem_wr_addr_o = wr_ptr.
- wr_ptr increments modulo DEPTH on each write.
REQ-009 SHALL move from FILL to ARMED in the cycle the PRE_TRIG-th sample is written; trigger matches during FILL SHALL be ignored.
REQ-010 SHALL detect a trigger in ARMED when sample_valid_i is high and (sample_i & trig_mask_i) == (trig_value_i & trig_mask_i). A zero mask triggers on the first valid sample.
REQ-011 SHALL write the trigger sample as post-sample 1. The block SHALL then stay in POST until DEPTH-PRE_TRIG post-samples are written, and go to READ in the cycle the last one is written.
REQ-012 SHALL start the readout at the oldest sample, which is wr_ptr after the final write. It SHALL read exactly DEPTH words in ascending order modulo DEPTH.
REQ-013 SHALL hold read data in a 2-entry output buffer. The block SHALL issue mem_ren_o only when (occupancy + in-flight reads − pop this cycle) < 2; this gives full throughput with no loss and no duplicates.
REQ-014 SHALL hold rd_data_o and rd_valid_o stable while rd_valid_o=1 and rd_ready_i=0. rd_valid_o SHALL first rise 2 cycles after entering READ.
REQ-015 SHALL assert rd_last_o with word DEPTH-1. On its handshake the block SHALL pulse done_o for one cycle and return to IDLE.
REQ-016 SHALL handle abort_i in any state: IDLE next cycle, write and read enables low that cycle, output buffer flushed, any in-flight read data discarded. abort_i SHALL take priority over a simultaneous arm_i, trigger, or handshake.
REQ-017 SHALL treat mem_wen_o and mem_ren_o as never simultaneously active, since the write and read phases are exclusive.

Reset
REQ-018 SHALL, while rst_n=0, force state IDLE, pointers and counters to 0, the buffer empty, and every output 0 except the combinational memory data, which follows its source.
REQ-019 SHALL abandon an in-progress capture or readout on reset with no further memory access. A new capture SHALL require a fresh arm_i.

Structure
REQ-020 SHALL place the state encodings and the state_o width in shared package la_pkg.
REQ-021 SHALL implement the 2-entry readout buffer as sub-module rd_skid_buf (DATA_LEN parameter, push/pop/count ports).
REQ-022 SHALL connect to sram_dp directly, with both of its clocks driven from clk.

Verification
REQ-023 SHALL cover a basic capture with DEPTH=16, PRE_TRIG=4, mask=0xFF, value=0x20, and ramp samples 0,1,2,…: exactly 16 words 28..43 are read out, rd_last_o is on 43, and done_o pulses once.
REQ-024 SHALL cover a zero mask with the same ramp: the trigger is sample 4 and the readout is 0..15.
REQ-025 SHALL cover a trigger inside FILL with value=0x02: the match at sample 2 is ignored and the trigger occurs at sample 18; the readout is 14..29.
REQ-026 SHALL cover backpressure with rd_ready_i following a random ~50% pattern: the readout sequence equals the no-backpressure case, and rd_data_o is stable while stalled.
REQ-027 SHALL cover abort_i in POST after 3 post-samples: IDLE next cycle, no further mem_wen_o, and a re-arm captures correctly.
REQ-028 SHALL cover rst_n low in READ at word 5: all outputs 0 and no mem_ren_o after release until a new capture reaches READ.
